// File: rtl/fpu_io_registers_if.sv
// CPU-side bus bundle for the FPU control/status register pair.
// The slave modport is the register block; the master modport is the CPU/decoder side.
interface fpu_io_registers_if;
  logic        control_cs;
  logic [15:0] control_data_in;
  logic        control_wr_en;
  logic        control_ack;
  logic [15:0] control_word_out;
  logic        control_write;
  logic        status_cs;
  logic [15:0] status_word_in;
  logic [15:0] status_data_out;
  logic        status_ack;

  modport slave (
    input  control_cs,
    input  control_data_in,
    input  control_wr_en,
    output control_ack,
    output control_word_out,
    output control_write,
    input  status_cs,
    input  status_word_in,
    output status_data_out,
    output status_ack
  );

  modport master (
    output control_cs,
    output control_data_in,
    output control_wr_en,
    input  control_ack,
    input  control_word_out,
    input  control_write,
    output status_cs,
    output status_word_in,
    input  status_data_out,
    input  status_ack
  );
endinterface

// File: rtl/fpu_io_registers.sv
// FPU control-word register (default 0x037F) with write strobe, plus a
// read-only status-word mirror; each port has its own select and acknowledge.
module fpu_io_registers (
  input  logic                       clk,
  input  logic                       reset,
  fpu_io_registers_if.slave          bus
);

  localparam logic [15:0] CW_DEFAULT = 16'h037F;

  logic [15:0] control_word_q, control_word_d;
  logic        control_write_q, control_write_d;
  logic        control_ack_q, control_ack_d;
  logic [15:0] status_data_q, status_data_d;
  logic        status_ack_q, status_ack_d;
  logic        wr_fire;

  assign wr_fire = bus.control_cs & bus.control_wr_en;

  always_comb begin
    control_word_d  = control_word_q;
    control_write_d = wr_fire;
    control_ack_d   = bus.control_cs;
    status_ack_d    = bus.status_cs;
    // Deselected status port drives zero so it can be OR-ed onto a shared bus.
    status_data_d   = bus.status_cs ? bus.status_word_in : 16'h0000;
    if (wr_fire) begin
      control_word_d = bus.control_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      control_word_q  <= CW_DEFAULT;
      control_write_q <= 1'b0;
      control_ack_q   <= 1'b0;
      status_data_q   <= 16'h0000;
      status_ack_q    <= 1'b0;
    end else begin
      control_word_q  <= control_word_d;
      control_write_q <= control_write_d;
      control_ack_q   <= control_ack_d;
      status_data_q   <= status_data_d;
      status_ack_q    <= status_ack_d;
    end
  end

  assign bus.control_word_out = control_word_q;
  assign bus.control_write    = control_write_q;
  assign bus.control_ack      = control_ack_q;
  assign bus.status_data_out  = status_data_q;
  assign bus.status_ack       = status_ack_q;

endmodule

// File: tb/tb_fpu_io_registers.sv
// Scoreboard bench for fpu_io_registers: a reference model pushes the expected
// post-edge outputs for every edge, and each test pops and compares them.
module tb_fpu_io_registers;

  typedef struct packed {
    logic [15:0] cw;
    logic        wr;
    logic        cack;
    logic [15:0] sdo;
    logic        sack;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  fpu_io_registers_if bus();

  fpu_io_registers dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  obs_t sb[$];
  logic [15:0] m_cw = 16'h037F;
  int checks = 0;
  int errors = 0;

  function automatic obs_t sample();
    obs_t o;
    o.cw   = bus.control_word_out;
    o.wr   = bus.control_write;
    o.cack = bus.control_ack;
    o.sdo  = bus.status_data_out;
    o.sack = bus.status_ack;
    return o;
  endfunction

  task automatic set_in(input logic ccs, input logic cwe, input logic [15:0] cd,
                        input logic scs, input logic [15:0] sw);
    bus.control_cs      = ccs;
    bus.control_wr_en   = cwe;
    bus.control_data_in = cd;
    bus.status_cs       = scs;
    bus.status_word_in  = sw;
  endtask

  // Reference model: predict outputs after the coming edge, then take the edge.
  task automatic step();
    obs_t e;
    if (reset) begin
      e.cw = 16'h037F; e.wr = 1'b0; e.cack = 1'b0; e.sdo = 16'h0000; e.sack = 1'b0;
    end else begin
      e.wr   = bus.control_cs && bus.control_wr_en;
      e.cw   = e.wr ? bus.control_data_in : m_cw;
      e.cack = bus.control_cs;
      e.sack = bus.status_cs;
      e.sdo  = bus.status_cs ? bus.status_word_in : 16'h0000;
    end
    m_cw = e.cw;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    reset = 1'b1;
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      reset = (i < 2);
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset[%0d] got=%h expected=%h", i, got, exp);
      end
    end
    checks++;
    if (bus.control_word_out !== 16'h037F) begin
      errors++;
      $display("FAIL reset_default_cw got=%h expected=037f", bus.control_word_out);
    end
  endtask

  task automatic test_write_strobe();
    obs_t got, exp;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) set_in(1'b1, 1'b1, 16'h0272, 1'b0, 16'h0000);
      else        set_in(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL write_strobe[%0d] got=%h expected=%h", i, got, exp);
      end
      checks++;
      if (bus.control_write !== (i == 0) || bus.control_word_out !== 16'h0272) begin
        errors++;
        $display("FAIL write_strobe_const[%0d] got cw=%h wr=%b", i, bus.control_word_out, bus.control_write);
      end
    end
  endtask

  task automatic test_control_ack();
    obs_t got, exp;
    for (int i = 0; i < 4; i++) begin
      set_in(i < 3, 1'b0, 16'hDEAD, 1'b0, 16'h0000);
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL control_ack[%0d] got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_status_read();
    obs_t got, exp;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 16'h0000, i == 1, 16'hABCD);
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL status_read[%0d] got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_streaming_status();
    obs_t got, exp;
    logic [15:0] vals [4] = '{16'h0001, 16'h8000, 16'h5A5A, 16'hA5A5};
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b0, 16'h0000, i < 4, (i < 4) ? vals[i] : 16'h1234);
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stream_status[%0d] got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  // Consecutive writes give consecutive strobes; both ports selected together.
  task automatic test_back_to_back();
    obs_t got, exp;
    logic [15:0] wd [4] = '{16'h1111, 16'hFFFF, 16'h0000, 16'h8001};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_in(1'b1, 1'b1, wd[i], 1'b1, ~wd[i]);
      else if (i == 4) set_in(1'b1, 1'b0, 16'h7777, 1'b1, 16'h0F0F);
      else set_in(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d] got=%h expected=%h", i, got, exp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 1), 16'($urandom),
             $urandom_range(0, 1), 16'($urandom));
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d] got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_after_write();
    obs_t got, exp;
    for (int i = 0; i < 4; i++) begin
      reset = (i == 1 || i == 2);
      if (i == 0)      set_in(1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h4321);
      else if (i < 3)  set_in(1'b1, 1'b1, 16'h1234, 1'b1, 16'h4321);
      else             set_in(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_after_write[%0d] got=%h expected=%h", i, got, exp);
      end
    end
    checks++;
    if (bus.control_word_out !== 16'h037F || bus.control_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard got cw=%h wr=%b expected cw=037f wr=0",
               bus.control_word_out, bus.control_write);
    end
  endtask

  initial begin
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    test_reset();
    test_write_strobe();
    test_control_ack();
    test_status_read();
    test_streaming_status();
    test_back_to_back();
    test_reset_after_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
